eeprom_page_ctrl: RTL and testbench

- Parametrised EEPROM transaction controller that sits between the user-side EEPROM control interface and the existing IIC byte driver (`iic_driver`).
- Accepts arbitrary-length read/write requests and buffers write data in an internal FIFO.
- Splits writes into page-aligned IIC bursts and inserts the EEPROM internal write-cycle delay (tWR) after each page write.
- Forwards read data back to the user.

---
 rtl/eeprom_page_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_eeprom_page_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_page_ctrl.sv
// rtl/eeprom_page_ctrl.sv - page-splitting EEPROM transaction controller in front of iic_driver
// Optional write-protect output o_eeprom_wp is built when EEPROM_WP_EN is defined.
module eeprom_page_ctrl #(
   parameter int         P_ADDR_WIDTH = 16,
   parameter int         P_PAGE_SIZE  = 32,
   parameter int         P_FIFO_DEPTH = 256,
   parameter int         P_TWR_CYCLES = 250000,
   parameter logic [3:0] P_DEV_TYPE   = 4'b1010
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [2:0]              i_ctrl_eeprom_addr,
   input  logic [P_ADDR_WIDTH-1:0] i_ctrl_operation_addr,
   input  logic [7:0]              i_ctrl_operation_len,
   input  logic                    i_ctrl_operation_type,
   input  logic                    i_ctrl_operation_valid,
   output logic                    o_ctrl_operation_ready,
   input  logic [7:0]              i_ctrl_write_data,
   input  logic                    i_ctrl_write_valid,
   output logic                    o_ctrl_write_ready,
   output logic [7:0]              o_ctrl_read_data,
   output logic                    o_ctrl_read_valid,
   output logic                    o_ctrl_done,
`ifdef EEPROM_WP_EN
   output logic                    o_eeprom_wp,
`endif
   output logic [6:0]              o_driver_addr,
   output logic [P_ADDR_WIDTH-1:0] o_operation_addr,
   output logic [7:0]              o_operation_len,
   output logic                    o_operation_type,
   output logic                    o_operation_valid,
   input  logic                    i_operation_ready,
   output logic [7:0]              o_write_data,
   input  logic                    i_write_req,
   input  logic [7:0]              i_read_data,
   input  logic                    i_read_valid
);

   localparam int FIFO_AW = $clog2(P_FIFO_DEPTH);
   localparam int PAGE_AW = $clog2(P_PAGE_SIZE);
   localparam int TWR_W   = $clog2(P_TWR_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_WAIT_DATA,
      S_ISSUE,
      S_XFER,
      S_TWR,
      S_NEXT,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic                    op_type;
   logic [P_ADDR_WIDTH-1:0] cur_addr;
   logic [7:0]              remaining;
   logic [7:0]              chunk;
   logic [6:0]              driver_addr;
   logic                    seen_busy;
   logic [TWR_W-1:0]        twr_cnt;

   logic [7:0]              fifo_mem [P_FIFO_DEPTH];
   logic [FIFO_AW-1:0]      wr_ptr;
   logic [FIFO_AW-1:0]      rd_ptr;
   logic [FIFO_AW:0]        fifo_count;
   logic                    fifo_full;
   logic                    push;
   logic                    pop;

   logic [8:0]              page_room;
   logic [7:0]              write_chunk;
   logic                    accept;

   // ---------------- write FIFO ----------------
   assign fifo_full = (fifo_count == (FIFO_AW + 1)'(P_FIFO_DEPTH));
   assign push      = i_ctrl_write_valid & ~fifo_full;
   assign pop       = i_write_req & (fifo_count != '0);

   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= i_ctrl_write_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count   <= '0;
         o_write_data <= 8'h00;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr       <= rd_ptr + 1'b1;
            o_write_data <= fifo_mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // ---------------- read return path ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ctrl_read_data  <= 8'h00;
         o_ctrl_read_valid <= 1'b0;
      end else begin
         o_ctrl_read_data  <= i_read_data;
         o_ctrl_read_valid <= i_read_valid;
      end
   end

   // Bytes left before the end of the current page; a write burst must not wrap inside a page.
   assign page_room   = 9'(P_PAGE_SIZE) - 9'(cur_addr[PAGE_AW-1:0]);
   assign write_chunk = ({1'b0, remaining} < page_room) ? remaining : page_room[7:0];
   assign accept      = (state == S_IDLE) & i_ctrl_operation_valid;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt              = state;
      o_ctrl_operation_ready = 1'b0;
      o_operation_valid      = 1'b0;
      o_ctrl_done            = 1'b0;
      case (state)
         S_IDLE: begin
            o_ctrl_operation_ready = 1'b1;
            if (i_ctrl_operation_valid) begin
               state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            if (remaining == 8'd0) begin
               state_nxt = S_DONE;
            end else if (op_type) begin
               state_nxt = S_ISSUE;
            end else begin
               state_nxt = S_WAIT_DATA;
            end
         end
         S_WAIT_DATA: begin
            if (int'(fifo_count) >= int'(chunk)) begin
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            o_operation_valid = 1'b1;
            if (i_operation_ready) begin
               state_nxt = S_XFER;
            end
         end
         S_XFER: begin
            // Burst ends when the driver has gone busy and become idle again.
            if (seen_busy && i_operation_ready) begin
               state_nxt = op_type ? S_NEXT : S_TWR;
            end
         end
         S_TWR: begin
            if (twr_cnt == TWR_W'(P_TWR_CYCLES - 1)) begin
               state_nxt = S_NEXT;
            end
         end
         S_NEXT: begin
            state_nxt = S_CALC;
         end
         S_DONE: begin
            o_ctrl_done = 1'b1;
            state_nxt   = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // ---------------- request datapath ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         op_type     <= 1'b0;
         cur_addr    <= '0;
         remaining   <= 8'd0;
         chunk       <= 8'd0;
         driver_addr <= 7'd0;
         seen_busy   <= 1'b0;
         twr_cnt     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_type     <= i_ctrl_operation_type;
                  cur_addr    <= i_ctrl_operation_addr;
                  remaining   <= i_ctrl_operation_len;
                  driver_addr <= {P_DEV_TYPE, i_ctrl_eeprom_addr};
               end
            end
            S_CALC: begin
               chunk <= op_type ? remaining : write_chunk;
            end
            S_ISSUE: begin
               seen_busy <= 1'b0;
            end
            S_XFER: begin
               twr_cnt <= '0;
               if (!i_operation_ready) begin
                  seen_busy <= 1'b1;
               end
            end
            S_TWR: begin
               twr_cnt <= twr_cnt + 1'b1;
            end
            S_NEXT: begin
               cur_addr  <= cur_addr + P_ADDR_WIDTH'(chunk);
               remaining <= remaining - chunk;
            end
            default: begin
            end
         endcase
      end
   end

   assign o_ctrl_write_ready = ~fifo_full;
   assign o_driver_addr      = driver_addr;
   assign o_operation_addr   = cur_addr;
   assign o_operation_len    = chunk;
   assign o_operation_type   = op_type;

`ifdef EEPROM_WP_EN
   // Protection is lifted only while a write request is in flight.
   assign o_eeprom_wp = ~((state != S_IDLE) & ~op_type);
`endif

endmodule

// File: tb/tb_eeprom_page_ctrl.sv
// tb/tb_eeprom_page_ctrl.sv - scoreboard bench for eeprom_page_ctrl with a random IIC driver model
`timescale 1ns/1ps
module tb_eeprom_page_ctrl;

   localparam int         AW    = 16;
   localparam int         PAGE  = 32;
   localparam int         DEPTH = 256;
   localparam int         TWR   = 16;
   localparam logic [3:0] DEV   = 4'b1010;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [2:0]    ctrl_eeprom_addr = '0;
   logic [AW-1:0] ctrl_op_addr = '0;
   logic [7:0]    ctrl_op_len = '0;
   logic          ctrl_op_type = 1'b0;
   logic          ctrl_op_valid = 1'b0;
   logic          ctrl_op_ready;
   logic [7:0]    ctrl_wdata = '0;
   logic          ctrl_wvalid = 1'b0;
   logic          ctrl_wready;
   logic [7:0]    ctrl_rdata;
   logic          ctrl_rvalid;
   logic          ctrl_done;
   logic [6:0]    driver_addr;
   logic [AW-1:0] op_addr;
   logic [7:0]    op_len;
   logic          op_type;
   logic          op_valid;
   logic          op_ready = 1'b1;
   logic [7:0]    write_data;
   logic          write_req = 1'b0;
   logic [7:0]    read_data = '0;
   logic          read_valid = 1'b0;
`ifdef EEPROM_WP_EN
   logic          eeprom_wp;
`endif

   eeprom_page_ctrl #(
      .P_ADDR_WIDTH(AW), .P_PAGE_SIZE(PAGE), .P_FIFO_DEPTH(DEPTH),
      .P_TWR_CYCLES(TWR), .P_DEV_TYPE(DEV)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_ctrl_eeprom_addr(ctrl_eeprom_addr),
      .i_ctrl_operation_addr(ctrl_op_addr),
      .i_ctrl_operation_len(ctrl_op_len),
      .i_ctrl_operation_type(ctrl_op_type),
      .i_ctrl_operation_valid(ctrl_op_valid),
      .o_ctrl_operation_ready(ctrl_op_ready),
      .i_ctrl_write_data(ctrl_wdata),
      .i_ctrl_write_valid(ctrl_wvalid),
      .o_ctrl_write_ready(ctrl_wready),
      .o_ctrl_read_data(ctrl_rdata),
      .o_ctrl_read_valid(ctrl_rvalid),
      .o_ctrl_done(ctrl_done),
`ifdef EEPROM_WP_EN
      .o_eeprom_wp(eeprom_wp),
`endif
      .o_driver_addr(driver_addr),
      .o_operation_addr(op_addr),
      .o_operation_len(op_len),
      .o_operation_type(op_type),
      .o_operation_valid(op_valid),
      .i_operation_ready(op_ready),
      .o_write_data(write_data),
      .i_write_req(write_req),
      .i_read_data(read_data),
      .i_read_valid(read_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         addr;
      int         len;
      logic       typ;
      logic [6:0] dev;
      bit         after_write;
   } op_t;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } rd_t;

   op_t        exp_ops[$];
   logic [7:0] fifo_model[$];
   rd_t        rd_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int pending_done = 0;
   int done_seen = 0;
   int last_done_cyc = 0;
   int last_burst_end = 0;
   int bursts = 0;
   bit wr_pend = 0;
   int acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitors ----------------
   op_t mon_op;
   rd_t mon_rd;
   always @(negedge clk) begin
      if (!rst) begin
         if (op_valid && op_ready) begin
            if (exp_ops.size() == 0) begin
               chk("op_unexpected", {op_addr, op_len, 7'd0, op_type}, 32'hFFFF_FFFF);
            end else begin
               mon_op = exp_ops.pop_front();
               chk("op_addr", 32'(op_addr), 32'(mon_op.addr));
               chk("op_len", 32'(op_len), 32'(mon_op.len));
               chk("op_type", 32'(op_type), 32'(mon_op.typ));
               chk("op_dev", 32'(driver_addr), 32'(mon_op.dev));
               if (mon_op.after_write)
                  chk("twr_gap_ok", 32'((cyc - last_burst_end) >= TWR), 32'd1);
            end
         end
         if (wr_pend) begin
            if (fifo_model.size() == 0) chk("wdata_underflow", 32'(write_data), 32'hFFFF_FFFF);
            else chk("wdata", 32'(write_data), 32'(fifo_model.pop_front()));
         end
         wr_pend = write_req;
         if (ctrl_rvalid) begin
            if (rd_q.size() == 0) begin
               chk("rdata_unexpected", 32'(ctrl_rdata), 32'hFFFF_FFFF);
            end else begin
               mon_rd = rd_q.pop_front();
               chk("rdata", 32'(ctrl_rdata), 32'(mon_rd.data));
               chk("rdata_cycle", 32'(cyc), 32'(mon_rd.cyc));
            end
         end
         if (ctrl_done) begin
            chk("done_expected", 32'(pending_done > 0), 32'd1);
            if (pending_done > 0) pending_done--;
            done_seen++;
            last_done_cyc = cyc;
         end
      end else begin
         wr_pend = 0;
      end
   end

   // ---------------- IIC driver model ----------------
   int         bfm_len;
   logic       bfm_type;
   rd_t        bfm_rd;
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && op_valid && op_ready) begin
            bfm_len  = int'(op_len);
            bfm_type = op_type;
            step();
            op_ready = 1'b0;
            for (int k = 0; k < bfm_len; k++) begin
               repeat ($urandom_range(0, 2)) step();
               if (bfm_type) begin
                  read_data   = 8'($urandom);
                  read_valid  = 1'b1;
                  bfm_rd.data = read_data;
                  bfm_rd.cyc  = cyc + 1;
                  rd_q.push_back(bfm_rd);
               end else begin
                  write_req = 1'b1;
               end
               step();
               write_req  = 1'b0;
               read_valid = 1'b0;
               read_data  = 8'($urandom);
            end
            repeat ($urandom_range(0, 2)) step();
            op_ready       = 1'b1;
            last_burst_end = cyc;
            bursts++;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_byte(input logic [7:0] b, input bit retry);
      int  n = 0;
      bit  acc;
      do begin
         ctrl_wdata  = b;
         ctrl_wvalid = 1'b1;
         @(negedge clk);
         acc = ctrl_wready;
         if (!retry) chk("write_ready", 32'(acc), 32'(fifo_model.size() < DEPTH));
         step();
         ctrl_wvalid = 1'b0;
         if (acc) fifo_model.push_back(b);
         n++;
      end while (retry && !acc && n < 20000);
      if (retry && !acc) chk("push_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_req(input int a, input int len, input logic t, input logic [2:0] d);
      int  rem = len;
      int  ad = a;
      int  c;
      int  room;
      int  n = 0;
      int  d0;
      bit  first = 1;
      op_t e;
      while (rem > 0) begin
         room = PAGE - (ad % PAGE);
         c = t ? rem : ((room < rem) ? room : rem);
         e.addr = ad; e.len = c; e.typ = t; e.dev = {DEV, d}; e.after_write = !t && !first;
         exp_ops.push_back(e);
         ad = (ad + c) % 65536;
         rem -= c;
         first = 0;
      end
      while (!ctrl_op_ready && n < 5000) begin step(); n++; end
      if (!ctrl_op_ready) chk("ready_timeout", 32'd0, 32'd1);
      ctrl_eeprom_addr = d;
      ctrl_op_addr     = AW'(a);
      ctrl_op_len      = 8'(len);
      ctrl_op_type     = t;
      ctrl_op_valid    = 1'b1;
      d0 = done_seen;
      pending_done++;
      step();
      ctrl_op_valid = 1'b0;
      acc_cyc = cyc;
      n = 0;
      while (done_seen == d0 && n < 20000) begin step(); n++; end
      chk("done_seen", 32'(done_seen != d0), 32'd1);
      chk("ready_after_done", 32'(ctrl_op_ready), 32'd1);
   endtask

   task automatic write_req_with_data(input int a, input int len, input logic [2:0] d);
      fork
         do_req(a, len, 1'b0, d);
         begin
            for (int i = 0; i < len; i++) begin
               repeat ($urandom_range(0, 1)) step();
               push_byte(8'($urandom), 1'b1);
            end
         end
      join
   endtask

   // ---------------- test sequence ----------------
   int b0;
   int dly;
   initial begin
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_op_ready", 32'(ctrl_op_ready), 32'd1);
      chk("rst_wr_ready", 32'(ctrl_wready), 32'd1);
      chk("rst_op_valid", 32'(op_valid), 32'd0);
      chk("rst_done", 32'(ctrl_done), 32'd0);
      chk("rst_rvalid", 32'(ctrl_rvalid), 32'd0);
      chk("rst_drv_addr", 32'(driver_addr), 32'd0);
      chk("rst_wdata", 32'(write_data), 32'd0);
      chk("rst_op_len", 32'(op_len), 32'd0);
`ifdef EEPROM_WP_EN
      chk("rst_wp", 32'(eeprom_wp), 32'd1);
`endif
      step();

      // single-page write
      for (int i = 0; i < 4; i++) push_byte(8'hA0 + 8'(i), 1'b0);
      do_req(16'h0010, 4, 1'b0, 3'd2);
      dly = last_done_cyc - last_burst_end;
      chk("done_after_twr", 32'(dly >= TWR && dly <= TWR + 4), 32'd1);

      // page-crossing write, data supplied after the request
      write_req_with_data(16'h001E, 5, 3'd1);

      // long sequential read
      do_req(16'h0100, 64, 1'b1, 3'd5);

      // address wrap and zero-length request
      for (int i = 0; i < 4; i++) push_byte(8'($urandom), 1'b0);
      do_req(16'hFFFE, 4, 1'b0, 3'd7);
      do_req(16'h1234, 0, 1'b0, 3'd0);
      chk("len0_done_latency", 32'((last_done_cyc - acc_cyc) <= 3), 32'd1);

      // random mix
      for (int r = 0; r < 10; r++) begin
         if ($urandom_range(0, 1) == 1)
            do_req(int'($urandom_range(0, 65535)), int'($urandom_range(0, 70)), 1'b1, 3'($urandom));
         else
            write_req_with_data(int'($urandom_range(0, 65535)), int'($urandom_range(0, 70)), 3'($urandom));
      end

      // FIFO full
      for (int i = 0; i < DEPTH; i++) push_byte(8'(i ^ 8'h5C), 1'b0);
      @(negedge clk);
      chk("full_wr_ready", 32'(ctrl_wready), 32'd0);
      step();
      push_byte(8'hEE, 1'b0);
      do_req(16'h0000, 32, 1'b0, 3'd3);

      // reset during the write-cycle delay of a two-chunk write
      b0 = bursts;
      fork
         do_req(16'h001E, 5, 1'b0, 3'd4);
      join_none
      dly = 0;
      while (bursts == b0 && dly < 5000) begin step(); dly++; end
      repeat (TWR / 2) step();
`ifdef EEPROM_WP_EN
      chk("twr_wp_low", 32'(eeprom_wp), 32'd0);
`endif
      disable fork;
      rst = 1'b1;
      exp_ops.delete();
      fifo_model.delete();
      pending_done = 0;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_op_ready", 32'(ctrl_op_ready), 32'd1);
      chk("mid_rst_wr_ready", 32'(ctrl_wready), 32'd1);
      chk("mid_rst_op_valid", 32'(op_valid), 32'd0);
`ifdef EEPROM_WP_EN
      chk("mid_rst_wp", 32'(eeprom_wp), 32'd1);
`endif
      ctrl_op_valid = 1'b0;
      repeat (TWR + 20) step();
      push_byte(8'h5A, 1'b0);
      do_req(16'h0040, 1, 1'b0, 3'd6);

      repeat (10) step();
      chk("ops_drained", 32'(exp_ops.size()), 32'd0);
      chk("reads_drained", 32'(rd_q.size()), 32'd0);
      chk("fifo_drained", 32'(fifo_model.size()), 32'd0);
      chk("done_balance", 32'(pending_done), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
